// File: rtl/alu_md.sv
// Execute-stage unit: zero-latency ALU plus a multi-cycle multiply/divide unit
// owning the HI/LO registers, with a start/busy handshake for pipeline stalls.
module alu_md #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Op,
   output logic [WIDTH-1:0] Out,
   output logic             Zero,
   output logic             Overflow,
   input  logic             md_start,
   input  logic [2:0]       md_op,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned SHW     = $clog2(WIDTH);
   localparam int unsigned HALF    = WIDTH / 2;
   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);

   // ---------------------------------------------------------------- ALU
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sh   = B[SHW-1:0];
   assign sum  = A + B;
   assign diff = A - B;

   always_comb begin
      Out      = '0;
      Overflow = 1'b0;
      case (Op)
         4'b0000: begin
            Out      = sum;
            Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0001: begin
            Out      = diff;
            Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0010: Out = A & B;
         4'b0011: Out = A | B;
         4'b0100: Out = A >> sh;
         4'b0101: Out = $unsigned($signed(A) >>> sh);
         4'b0110: Out = A << sh;
         4'b0111: Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'b1000: Out = {{(WIDTH-1){1'b0}}, (A < B)};
         4'b1001: Out = A ^ B;
         4'b1010: Out = ~(A | B);
         4'b1011: Out = B << HALF;
         default: Out = '0;
      endcase
   end

   assign Zero = (Out == '0);

   // ------------------------------------------------------- md datapath
   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // op_q[0] selects unsigned, op_q[1] selects divide
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_div;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               div_by_zero;
   logic [WIDTH-1:0]   md_hi_d;
   logic [WIDTH-1:0]   md_lo_d;
   logic               md_wr_d;

   assign a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   // Signed divide via magnitudes; MIN/-1 wraps back to MIN with remainder 0
   assign a_neg       = ~op_q[0] & a_q[WIDTH-1];
   assign b_neg       = ~op_q[0] & b_q[WIDTH-1];
   assign a_mag       = a_neg ? (~a_q + WIDTH'(1)) : a_q;
   assign b_mag       = b_neg ? (~b_q + WIDTH'(1)) : b_q;
   assign div_by_zero = (b_q == '0);
   assign b_div       = div_by_zero ? WIDTH'(1) : b_mag;
   assign q_mag       = a_mag / b_div;
   assign r_mag       = a_mag % b_div;
   assign quot        = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
   assign rem         = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

   assign md_hi_d = op_q[1] ? rem  : prod[2*WIDTH-1:WIDTH];
   assign md_lo_d = op_q[1] ? quot : prod[WIDTH-1:0];
   assign md_wr_d = ~(op_q[1] & div_by_zero);

   // ----------------------------------------------------------- md FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (md_start) begin
                  case (md_op)
                     3'b000, 3'b001: begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= md_op[1:0];
                        cnt_q   <= CW'(MUL_LAT);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                     end
                     3'b010, 3'b011: begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= md_op[1:0];
                        cnt_q   <= CW'(DIV_LAT);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                     end
                     3'b100:  hi_q <= A;
                     3'b101:  lo_q <= A;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                  if (md_wr_d) begin
                     hi_q <= md_hi_d;
                     lo_q <= md_lo_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_alu_md;

   localparam int unsigned W  = 32;
   localparam int unsigned ML = 5;
   localparam int unsigned DL = 10;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 64'sd1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [3:0]   Op;
   logic [W-1:0] Out;
   logic         Zero;
   logic         Overflow;
   logic         md_start;
   logic [2:0]   md_op;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks   = 0;
   int failures = 0;

   // model state: completion of a pending op happens LAT edges after acceptance
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   logic         m_busy, p_wr;
   int           m_left;

   always #5 clk = ~clk;

   alu_md #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op), .Out(Out), .Zero(Zero),
      .Overflow(Overflow), .md_start(md_start), .md_op(md_op), .busy(busy),
      .hi(hi), .lo(lo)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op, output logic [W-1:0] o,
                                   output logic ov);
      longint s;
      o  = '0;
      ov = 1'b0;
      case (op)
         4'd0: begin
            s  = longint'($signed(a)) + longint'($signed(b));
            o  = 32'(s);
            ov = (s > SMAX) || (s < SMIN);
         end
         4'd1: begin
            s  = longint'($signed(a)) - longint'($signed(b));
            o  = 32'(s);
            ov = (s > SMAX) || (s < SMIN);
         end
         4'd2:  o = a & b;
         4'd3:  o = a | b;
         4'd4:  o = a >> b[4:0];
         4'd5:  o = $unsigned($signed(a) >>> b[4:0]);
         4'd6:  o = a << b[4:0];
         4'd7:  o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  o = (a < b) ? 32'd1 : 32'd0;
         4'd9:  o = a ^ b;
         4'd10: o = ~(a | b);
         4'd11: o = {b[15:0], 16'h0000};
         default: o = '0;
      endcase
   endfunction

   function automatic void model_step();
      longint       sa, sb, q, r, p;
      logic [63:0]  u;
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0; p_wr = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            if (p_wr) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
         end
      end else if (md_start) begin
         case (md_op)
            3'd0: begin
               p = longint'($signed(A)) * longint'($signed(B));
               p_hi = 32'(p >>> 32); p_lo = 32'(p); p_wr = 1'b1;
               m_busy = 1'b1; m_left = ML;
            end
            3'd1: begin
               u = {32'h0, A} * {32'h0, B};
               p_hi = u[63:32]; p_lo = u[31:0]; p_wr = 1'b1;
               m_busy = 1'b1; m_left = ML;
            end
            3'd2: begin
               p_wr = (B != '0);
               if (p_wr) begin
                  sa = longint'($signed(A)); sb = longint'($signed(B));
                  q = sa / sb; r = sa % sb;
                  p_lo = 32'(q); p_hi = 32'(r);
               end
               m_busy = 1'b1; m_left = DL;
            end
            3'd3: begin
               p_wr = (B != '0);
               if (p_wr) begin
                  p_lo = A / B; p_hi = A % B;
               end
               m_busy = 1'b1; m_left = DL;
            end
            3'd4: m_hi = A;
            3'd5: m_lo = A;
            default: ;
         endcase
      end
   endfunction

   // per-cycle comparison against the model
   initial begin
      logic [W-1:0] eo;
      logic         eov;
      forever begin
         @(posedge clk);
         model_step();
         #1;
         alu_ref(A, B, Op, eo, eov);
         check("alu_out", Out, eo);
         check("alu_zero", 32'(Zero), 32'(eo == '0));
         check("alu_ovf", 32'(Overflow), 32'(eov));
         check("md_busy", 32'(busy), 32'(m_busy));
         check("md_hi", hi, m_hi);
         check("md_lo", lo, m_lo);
      end
   end

   task automatic md_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      md_start = 1'b1; md_op = op; A = a; B = b;
      @(negedge clk);
      md_start = 1'b0; A = $urandom; B = $urandom;
   endtask

   task automatic md_wait(output int n);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL md_wait_timeout: busy still high after %0d cycles", n);
      end
   endtask

   task automatic alu_lit(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eo, input logic ez,
                          input logic eov);
      @(negedge clk);
      Op = op; A = a; B = b;
      #1;
      check({name, "_out"}, Out, eo);
      check({name, "_zero"}, 32'(Zero), 32'(ez));
      check({name, "_ovf"}, 32'(Overflow), 32'(eov));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; md_start = 1'b0; md_op = 3'd0; A = '0; B = '0; Op = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);

      alu_lit("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
      alu_lit("sub_zero", 4'b0001, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
      alu_lit("sub_ovf", 4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
      alu_lit("sra", 4'b0101, 32'h80000000, 32'h21, 32'hC0000000, 1'b0, 1'b0);
      alu_lit("lui", 4'b1011, 32'hDEAD0000, 32'h1234, 32'h12340000, 1'b0, 1'b0);
      alu_lit("dflt", 4'b1111, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
      alu_lit("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
      alu_lit("sltu", 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);

      md_issue(3'd0, 32'hFFFFFFFF, 32'd2);
      md_wait(n);
      check("mult_cycles", 32'(n), 32'd5);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFE);
      check("model_mult_hi", m_hi, 32'hFFFFFFFF);

      md_issue(3'd1, 32'hFFFFFFFF, 32'd2);
      md_wait(n);
      check("multu_hi", hi, 32'h1);
      check("multu_lo", lo, 32'hFFFFFFFE);

      md_issue(3'd2, 32'hFFFFFFF9, 32'd2);
      md_wait(n);
      check("div_cycles", 32'(n), 32'd10);
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_lo", lo, 32'hFFFFFFFD);
      check("model_div_lo", m_lo, 32'hFFFFFFFD);

      md_issue(3'd5, 32'h55, 32'h0);
      check("mtlo_busy", 32'(busy), 32'd0);
      check("mtlo_lo", lo, 32'h55);
      md_issue(3'd2, 32'h1234, 32'h0);
      md_wait(n);
      check("div0_cycles", 32'(n), 32'd10);
      check("div0_lo", lo, 32'h55);
      check("div0_hi", hi, 32'hFFFFFFFF);

      md_issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      md_wait(n);
      check("divmin_lo", lo, 32'h80000000);
      check("divmin_hi", hi, 32'h0);

      md_issue(3'd2, 32'd100, 32'd7);
      @(negedge clk);
      md_start = 1'b1; md_op = 3'd4; A = 32'hAA; B = 32'd3;
      @(negedge clk);
      md_start = 1'b0; A = $urandom; B = $urandom;
      md_wait(n);
      check("ign_lo", lo, 32'd14);
      check("ign_hi", hi, 32'd2);

      md_issue(3'd0, 32'd3, 32'd4);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      repeat (8) @(negedge clk);
      check("abort_hi_late", hi, 32'h0);
      check("abort_lo_late", lo, 32'h0);

      for (int i = 0; i < 600; i++) begin
         int unsigned r;
         @(negedge clk);
         A  = $urandom;
         B  = $urandom;
         Op = 4'($urandom);
         r  = $urandom_range(0, 15);
         if (r == 0) B = '0;
         if (r == 1) begin A = 32'h80000000; B = 32'hFFFFFFFF; end
         if (r == 2) B = {27'h0, 5'($urandom)};
         md_start = ($urandom_range(0, 3) == 0);
         md_op    = 3'($urandom_range(0, 7));
         rst_n    = ($urandom_range(0, 199) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; md_start = 1'b0;
      md_wait(n);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised next-generation execute-stage unit for the MIPS datapath.
- Zero-latency combinational ALU: superset of the existing 4-bit Op set, plus XOR/NOR/LUI, overflow detection and a defined default.
- Multi-cycle multiply/divide unit with HI/LO registers and a start/busy handshake, so the pipeline can stall on mfhi/mflo and further md ops.

Parameters:
WIDTH, 32, datapath width in bits; must be even, ≥8, a power of two.
MUL_LAT, 5, cycles from accepted mult/multu to HI/LO update; ≥1.
DIV_LAT, 10, cycles from accepted div/divu to HI/LO update; ≥1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
A  in  WIDTH  operand A (rs)
B  in  WIDTH  operand B (rt/imm); shift amount = B[log2(WIDTH)-1:0]
Op  in  4  ALU operation select
Out  out  WIDTH  ALU result (combinational)
Zero  out  1  Out == 0
Overflow  out  1  signed overflow for Op 0000/0001, else 0
md_start  in  1  request md operation this cycle
md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others reserved
busy  out  1  md unit occupied (registered)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: clk is the single clock; rst_n is synchronous and active-low.
- Reset: on a clk edge with rst_n=0, state←IDLE, busy←0, hi←0, lo←0, counter←0. Reset mid-operation aborts the op; no HI/LO write occurs. Out/Zero/Overflow are combinational, no reset.
- ALU Op map:
  - 0000 A+B
  - 0001 A−B
  - 0010 A&B
  - 0011 A|B
  - 0100 A>>sh (logical)
  - 0101 A>>>sh (arithmetic)
  - 0110 A<<sh
  - 0111 signed A<B (1/0)
  - 1000 unsigned A<B
  - 1001 A^B
  - 1010 ~(A|B)
  - 1011 B<<(WIDTH/2)
  - 1100–1111 Out=0
- Overflow: for add, set when A and B have equal MSBs and the sum MSB differs. For sub, set when A and B MSBs differ and the result MSB differs from A's. Out still carries the wrapped result.
- Zero is asserted exactly when Out==0, including for the default ops.
- md FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter active.
- IDLE, md_start=1, md_op mult/multu/div/divu: on the edge, latch A, B and op; counter←MUL_LAT or DIV_LAT; →RUN. busy reads 1 from that edge.
- RUN, each edge: counter←counter−1. On the edge where counter==1, write {hi,lo} and →IDLE; busy falls on the same edge. Net effect: request accepted at edge k gives hi/lo updated and busy=0 at edge k+LAT.
- mult: {hi,lo}=signed 2·WIDTH product. multu: unsigned product.
- div: lo=quotient truncated toward zero; hi=remainder, sign follows dividend. divu: unsigned quotient/remainder.
- Divide by zero: full DIV_LAT busy period, then hi/lo left unchanged.
- Signed MIN/−1: lo=MIN (100…0), hi=0.
- mthi/mtlo in IDLE: hi←A (or lo←A) on that edge; busy stays 0; single cycle.
- md_start while busy=1: ignored entirely, no effect on operands, counter or HI/LO. The pipeline must stall instead.
- Reserved md_op with md_start=1: ignored.
- Results are computed from the latched operands only; A/B changes during RUN have no effect.
- ALU path is independent of busy and usable every cycle.

Test Plan:
1. Op=0000, A=0x7FFFFFFF, B=1 → Out=0x80000000, Overflow=1, Zero=0. Op=0001, A=B=5 → Out=0, Zero=1, Overflow=0.
2. Op=0101, A=0x80000000, B=0x21 (sh=1) → Out=0xC0000000. Op=1011, B=0x1234 → Out=0x12340000. Op=1111 → Out=0, Zero=1.
3. mult, A=0xFFFFFFFF (−1), B=2, start at edge k → busy=1 on edges k..k+4; at edge k+5, hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0. multu, same operands → hi=1, lo=0xFFFFFFFE.
4. div, A=−7, B=2 → after 10 cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). div with B=0 after mtlo A=0x55 → busy 10 cycles, lo stays 0x55.
5. div start; at cycle 3 assert md_start mthi with A=0xAA and change A/B → ignored; final hi/lo come from the original operands.
6. mult in progress; rst_n=0 at cycle 2 → next edge busy=0, hi=lo=0; no later write occurs.
